// File: rtl/mmcm_drp_arbiter.sv
// Round-robin arbiter sharing one MMCM/PLL DRP port between requesters,
// with a drdy timeout and a per-requester bus and MMCM-reset lock.
module mmcm_drp_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  dclk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [7*NUM_REQ-1:0]  req_addr,
    input  logic [16*NUM_REQ-1:0] req_di,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ-1:0]    req_rst_mmcm,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_do,
    output logic                  rsp_timeout,
    output logic [6:0]            daddr,
    output logic [15:0]           din,
    output logic                  den,
    output logic                  dwe,
    input  logic [15:0]           dout,
    input  logic                  drdy,
    output logic                  rst_mmcm,
    output logic                  busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      owner_d;
    logic [IW-1:0]      cur_q;
    logic [IW-1:0]      gnt;
    logic               lock_q;
    logic               lock_d;
    logic               lock_eff;
    logic               found;
    logic [NUM_REQ-1:0] elig;
    logic [9:0]         cnt_q;
    logic [6:0]         addr_q;
    logic [15:0]        di_q;
    logic               den_q;
    logic               dwe_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [15:0]        rsp_do_q;
    logic               rsp_to_q;
    logic               rst_mmcm_q;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_REQ);
    endfunction

    // A lock whose owner has dropped req_lock is released in the
    // same IDLE cycle, so the others compete immediately.
    always_comb begin
        lock_eff = lock_q & req_lock[owner_q];
        elig     = '0;
        if (state_q == IDLE && !rst) begin
            if (lock_eff) begin
                elig[owner_q] = req_valid[owner_q];
            end else begin
                elig = req_valid;
            end
        end
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[wrap(int'(ptr_q) + k)]) begin
                found = 1'b1;
                gnt   = wrap(int'(ptr_q) + k);
            end
        end
        lock_d  = lock_q;
        owner_d = owner_q;
        if (state_q == IDLE) begin
            lock_d = lock_eff;
            if (found && req_lock[gnt]) begin
                lock_d  = 1'b1;
                owner_d = gnt;
            end
        end
        req_ready = '0;
        if (found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cur_q       <= '0;
            lock_q      <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            di_q        <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_do_q    <= '0;
            rsp_to_q    <= 1'b0;
            rst_mmcm_q  <= 1'b0;
        end else begin
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_to_q    <= 1'b0;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rst_mmcm_q  <= lock_d & req_rst_mmcm[owner_d];
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        cur_q   <= gnt;
                        addr_q  <= req_addr[int'(gnt)*7 +: 7];
                        di_q    <= req_di[int'(gnt)*16 +: 16];
                        den_q   <= 1'b1;
                        dwe_q   <= req_we[gnt];
                        state_q <= ISSUE;
                        if (!lock_eff) begin
                            ptr_q <= wrap(int'(gnt) + 1);
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (drdy) begin
                        state_q            <= IDLE;
                        rsp_valid_q[cur_q] <= 1'b1;
                        rsp_do_q           <= dout;
                    end else if (cnt_q == TO_LAST) begin
                        state_q            <= IDLE;
                        rsp_valid_q[cur_q] <= 1'b1;
                        rsp_do_q           <= '0;
                        rsp_to_q           <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_do      = rsp_do_q;
    assign rsp_timeout = rsp_to_q;
    assign daddr       = addr_q;
    assign din         = di_q;
    assign den         = den_q;
    assign dwe         = dwe_q;
    assign rst_mmcm    = rst_mmcm_q;
    assign busy        = (state_q != IDLE) | lock_q;

endmodule

// File: tb/tb_mmcm_drp_arbiter.sv
// Bench for mmcm_drp_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin reference model.
module tb_mmcm_drp_arbiter;
    localparam int N  = 2;
    localparam int TO = 16;

    logic          dclk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_we;
    logic [7*N-1:0]  req_addr;
    logic [16*N-1:0] req_di;
    logic [N-1:0]  req_lock;
    logic [N-1:0]  req_rst_mmcm;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [15:0]   rsp_do;
    logic          rsp_timeout;
    logic [6:0]    daddr;
    logic [15:0]   din;
    logic          den;
    logic          dwe;
    logic [15:0]   dout;
    logic          drdy;
    logic          rst_mmcm;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    always #5 dclk = ~dclk;

    mmcm_drp_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .dclk(dclk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_di(req_di),
        .req_lock(req_lock), .req_rst_mmcm(req_rst_mmcm),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_do(rsp_do), .rsp_timeout(rsp_timeout),
        .daddr(daddr), .din(din), .den(den), .dwe(dwe),
        .dout(dout), .drdy(drdy),
        .rst_mmcm(rst_mmcm), .busy(busy)
    );

    task automatic idle_in;
        req_valid    = '0;
        req_we       = '0;
        req_addr     = '0;
        req_di       = '0;
        req_lock     = '0;
        req_rst_mmcm = '0;
        drdy         = 1'b0;
        dout         = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge dclk);
        #1;
        req_valid = 2'b11;
        @(negedge dclk);
        checks++;
        if ({rsp_valid, rsp_do, rsp_timeout, daddr, din, den, dwe,
             rst_mmcm, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {rsp_valid, rsp_do, rsp_timeout, daddr, din, den,
                      dwe, rst_mmcm, busy});
        end
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
        req_valid = '0;
        rst = 1'b0;
        mptr = 0;
    endtask

    task automatic test_single_read;
        logic [N-1:0] er;
        for (int c = 0; c < 8; c++) begin
            @(posedge dclk); #1;
            req_valid = {1'b0, c == 0};
            req_addr[6:0] = 7'h08;
            req_we[0] = 1'b0;
            drdy = (c == 4);
            dout = (c == 4) ? 16'h1041 : 16'($urandom);
            @(negedge dclk);
            er = (c == 0) ? 2'b01 : 2'b00;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL rd_ready c=%0d got=%b exp=%b", c, req_ready, er);
            end
            checks++;
            if (den !== (c == 1)) begin
                failures++;
                $display("FAIL rd_den c=%0d got=%b exp=%b", c, den, c == 1);
            end
            if (c == 1) begin
                checks++;
                if (dwe !== 1'b0 || daddr !== 7'h08) begin
                    failures++;
                    $display("FAIL rd_issue got=%b/%h exp=0/08", dwe, daddr);
                end
            end
            er = (c == 5) ? 2'b01 : 2'b00;
            checks++;
            if (rsp_valid !== er) begin
                failures++;
                $display("FAIL rd_rsp c=%0d got=%b exp=%b", c, rsp_valid, er);
            end
            if (c == 5) begin
                checks++;
                if (rsp_do !== 16'h1041 || rsp_timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL rd_data got=%h/%b exp=1041/0",
                             rsp_do, rsp_timeout);
                end
            end
        end
        mptr = 1;
        idle_in();
    endtask

    // Requesters hold valid until ready; the model picks the grant from
    // the round-robin rule and derives every latency from acceptance time.
    task automatic test_traffic(input bit rnd, input int ncyc);
        logic [N-1:0]  pv;
        logic [N-1:0]  pw;
        logic [6:0]    pa[N];
        logic [15:0]   pd[N];
        logic [N-1:0]  er;
        logic [6:0]    ea;
        logic [15:0]   ed;
        logic [15:0]   md;
        logic          ew;
        logic          free;
        int cur, den_c, drdy_c, rsp_c, g, j;
        free = 1'b1; pv = '0; pw = '0;
        cur = 0; den_c = -1; drdy_c = -1; rsp_c = -1;
        ea = '0; ed = '0; ew = 1'b0; md = '0;
        for (int c = 0; c < ncyc + 100; c++) begin
            if (c >= ncyc && free && pv == '0) break;
            @(posedge dclk); #1;
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && c < ncyc &&
                    (!rnd || $urandom_range(0, 2) == 0)) begin
                    pv[i] = 1'b1;
                    pa[i] = 7'($urandom);
                    pd[i] = 16'($urandom);
                    pw[i] = 1'($urandom);
                end
                req_addr[7*i +: 7]  = pa[i];
                req_di[16*i +: 16]  = pd[i];
            end
            req_valid = pv;
            req_we    = pw;
            drdy = (c == drdy_c);
            dout = drdy ? md : 16'($urandom);
            @(negedge dclk);
            er = '0;
            if (c == rsp_c) er[cur] = 1'b1;
            checks++;
            if (rsp_valid !== er) begin
                failures++;
                $display("FAIL tr_rsp c=%0d got=%b exp=%b", c, rsp_valid, er);
            end
            if (c == rsp_c) begin
                checks++;
                if (rsp_do !== md || rsp_timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL tr_data c=%0d got=%h/%b exp=%h/0",
                             c, rsp_do, rsp_timeout, md);
                end
                free = 1'b1;
            end
            checks++;
            if (den !== (c == den_c)) begin
                failures++;
                $display("FAIL tr_den c=%0d got=%b exp=%b", c, den, c == den_c);
            end
            if (c == den_c) begin
                checks++;
                if ({daddr, din, dwe} !== {ea, ed, ew}) begin
                    failures++;
                    $display("FAIL tr_issue c=%0d got=%h/%h/%b exp=%h/%h/%b",
                             c, daddr, din, dwe, ea, ed, ew);
                end
            end
            checks++;
            if (busy !== !free) begin
                failures++;
                $display("FAIL tr_busy c=%0d got=%b exp=%b", c, busy, !free);
            end
            g = -1;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (g < 0 && pv[j]) g = j;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL tr_ready c=%0d got=%b exp=%b", c, req_ready, er);
            end
            if (g >= 0) begin
                cur = g;
                ea = pa[g]; ed = pd[g]; ew = pw[g];
                pv[g] = 1'b0;
                mptr = (g + 1) % N;
                free = 1'b0;
                den_c = c + 1;
                drdy_c = c + 1 + (rnd ? $urandom_range(1, 6) : 2);
                rsp_c = drdy_c + 1;
                md = 16'($urandom);
            end
        end
        checks++;
        if (!free || pv != '0) begin
            failures++;
            $display("FAIL tr_drain got=%b/%b exp=1/0", free, pv);
        end
        idle_in();
    endtask

    task automatic test_lock;
        logic [6:0]  la[3];
        logic [15:0] ld[3];
        logic [N-1:0] er;
        la[0] = 7'h08; la[1] = 7'h09; la[2] = 7'h14;
        for (int t = 0; t < 3; t++) ld[t] = 16'($urandom);
        for (int c = 0; c < 25; c++) begin
            @(posedge dclk); #1;
            req_valid[1]    = (c < 18) && (c % 6 == 0);
            req_lock[1]     = (c < 18);
            req_rst_mmcm[1] = 1'b1;
            req_we[1]       = 1'b1;
            req_addr[13:7]  = la[(c < 18) ? c / 6 : 2];
            req_di[31:16]   = ld[(c < 18) ? c / 6 : 2];
            req_valid[0]    = (c >= 1) && (c <= 18);
            req_lock[0]     = 1'b0;
            req_rst_mmcm[0] = 1'b1;
            req_we[0]       = 1'b0;
            req_addr[6:0]   = 7'h20;
            drdy = ((c < 18) && (c % 6 == 3)) || (c == 21);
            dout = 16'($urandom);
            @(negedge dclk);
            er = ((c < 18) && (c % 6 == 0)) ? 2'b10 :
                 (c == 18) ? 2'b01 : 2'b00;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL lk_ready c=%0d got=%b exp=%b", c, req_ready, er);
            end
            if ((c < 18) && (c % 6 == 1)) begin
                checks++;
                if ({den, dwe, daddr, din} !== {2'b11, la[c/6], ld[c/6]}) begin
                    failures++;
                    $display("FAIL lk_issue c=%0d got=%b%b/%h/%h exp=11/%h/%h",
                             c, den, dwe, daddr, din, la[c/6], ld[c/6]);
                end
            end
            er = ((c < 18) && (c % 6 == 4)) ? 2'b10 :
                 (c == 22) ? 2'b01 : 2'b00;
            checks++;
            if (rsp_valid !== er) begin
                failures++;
                $display("FAIL lk_rsp c=%0d got=%b exp=%b", c, rsp_valid, er);
            end
            checks++;
            if (rst_mmcm !== (c >= 1 && c <= 18)) begin
                failures++;
                $display("FAIL lk_rst_mmcm c=%0d got=%b exp=%b",
                         c, rst_mmcm, c >= 1 && c <= 18);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 21)) begin
                failures++;
                $display("FAIL lk_busy c=%0d got=%b exp=%b",
                         c, busy, c >= 1 && c <= 21);
            end
        end
        mptr = 1;
        idle_in();
    endtask

    task automatic test_timeout;
        logic [N-1:0] er;
        for (int c = 0; c < TO + 13; c++) begin
            @(posedge dclk); #1;
            req_valid = {1'b0, c == 0};
            req_addr[6:0] = 7'h11;
            drdy = (c == TO + 7);
            dout = 16'($urandom) | 16'h0001;
            @(negedge dclk);
            er = (c == 0) ? 2'b01 : 2'b00;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL to_ready c=%0d got=%b exp=%b", c, req_ready, er);
            end
            er = (c == TO + 2) ? 2'b01 : 2'b00;
            checks++;
            if (rsp_valid !== er) begin
                failures++;
                $display("FAIL to_rsp c=%0d got=%b exp=%b", c, rsp_valid, er);
            end
            if (c == TO + 2) begin
                checks++;
                if (rsp_timeout !== 1'b1 || rsp_do !== 16'h0000) begin
                    failures++;
                    $display("FAIL to_flag got=%b/%h exp=1/0000",
                             rsp_timeout, rsp_do);
                end
            end
            if (c == TO + 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL to_busy got=%b exp=1", busy);
                end
            end
        end
        mptr = 1;
        idle_in();
    endtask

    task automatic test_back_to_back;
        int L;
        int acc[$];
        int dens[$];
        int rsps[$];
        L = $urandom_range(1, 3);
        for (int c = 0; c < 2 * L + 12; c++) begin
            @(posedge dclk); #1;
            req_valid = {1'b0, acc.size() < 2};
            req_addr[6:0] = 7'h08 + 7'(acc.size());
            drdy = (dens.size() > 0 && c == dens[0] + L) ||
                   (dens.size() > 1 && c == dens[1] + L);
            dout = 16'($urandom);
            @(negedge dclk);
            if (req_ready[0] === 1'b1) acc.push_back(c);
            if (den === 1'b1) dens.push_back(c);
            if (rsp_valid[0] === 1'b1) rsps.push_back(c);
        end
        checks++;
        if (acc.size() != 2 || dens.size() != 2 || rsps.size() != 2) begin
            failures++;
            $display("FAIL b2b_counts got=%0d/%0d/%0d exp=2/2/2",
                     acc.size(), dens.size(), rsps.size());
        end else begin
            checks++;
            if (acc[0] != 0 || dens[0] != 1) begin
                failures++;
                $display("FAIL b2b_first got=%0d/%0d exp=0/1", acc[0], dens[0]);
            end
            checks++;
            if (rsps[0] != L + 2) begin
                failures++;
                $display("FAIL b2b_rsp got=%0d exp=%0d", rsps[0], L + 2);
            end
            checks++;
            if (acc[1] != rsps[0]) begin
                failures++;
                $display("FAIL b2b_overlap got=%0d exp=%0d", acc[1], rsps[0]);
            end
            checks++;
            if (dens[1] - dens[0] != L + 2) begin
                failures++;
                $display("FAIL b2b_gap got=%0d exp=%0d",
                         dens[1] - dens[0], L + 2);
            end
        end
        mptr = 1;
        idle_in();
    endtask

    task automatic test_reset_in_wait;
        logic [N-1:0] er;
        logic [15:0]  d;
        d = 16'($urandom);
        for (int c = 0; c < 13; c++) begin
            @(posedge dclk); #1;
            rst = (c == 3);
            req_valid[0] = (c == 0) || (c == 5);
            req_valid[1] = (c >= 5) && (c <= 8);
            req_addr[6:0] = 7'h2a;
            req_addr[13:7] = 7'h15;
            drdy = (c == 4) || (c == 7) || (c == 10);
            dout = (c == 7) ? d : 16'($urandom);
            @(negedge dclk);
            er = (c == 0 || c == 5) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL rw_ready c=%0d got=%b exp=%b", c, req_ready, er);
            end
            if (c == 4) begin
                checks++;
                if ({den, dwe, busy} !== 3'b000) begin
                    failures++;
                    $display("FAIL rw_abort got=%b%b%b exp=000", den, dwe, busy);
                end
            end
            if (c == 6) begin
                checks++;
                if (den !== 1'b1 || daddr !== 7'h2a) begin
                    failures++;
                    $display("FAIL rw_issue got=%b/%h exp=1/2a", den, daddr);
                end
            end
            er = (c == 8) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
            checks++;
            if (rsp_valid !== er) begin
                failures++;
                $display("FAIL rw_rsp c=%0d got=%b exp=%b", c, rsp_valid, er);
            end
            if (c == 8) begin
                checks++;
                if (rsp_do !== d) begin
                    failures++;
                    $display("FAIL rw_data got=%h exp=%h", rsp_do, d);
                end
            end
        end
        mptr = 0;
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_traffic(1'b0, 40);
        test_lock();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        test_traffic(1'b1, 600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
